vga_decoder: RTL
================

# vga_decoder

Receive-side VGA timing decoder for the Space Invaders display path. It samples the `hsync`, `vsync`, `red`, `green` and `blue` signals produced by `vga_controller` and locks onto the 800x600@56 Hz raster clocked at 36 MHz. It reconstructs pixel coordinates and colour, flags timing violations, and reports per-frame statistics. It is used for on-board self-check and as the scoreboard front end in display testbenches.

## Interface

**Parameters**

- `H_VISIBLE`, 800, visible pixels per line
- `H_FRONT`, 24, horizontal front porch in clocks
- `H_SYNC`, 72, hsync pulse width in clocks
- `H_BACK`, 128, horizontal back porch in clocks
- `V_VISIBLE`, 600, visible lines per frame
- `V_FRONT`, 1, vertical front porch in lines
- `V_SYNC`, 2, vsync pulse width in lines
- `V_BACK`, 22, vertical back porch in lines
- `SYNC_POL`, 1, asserted level of `hsync`/`vsync`

Derived values: H_TOTAL = 1024 and V_TOTAL = 625 for the defaults.

**Ports**

- `clk_36MHz` in 1: the single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `hsync`, `vsync` in 1: sync inputs from the raster source.
- `red`, `green`, `blue` in 1: colour inputs.
- `locked` out 1: high in the LOCKED state.
- `pix_valid` out 1: high when the current output pixel is visible and the decoder is locked.
- `pix_x` out 10: column, 0..H_VISIBLE-1.
- `pix_y` out 10: row, 0..V_VISIBLE-1.
- `pix_rgb` out 3: colour as {red, green, blue}.
- `frame_start` out 1: one-cycle pulse with pixel (0,0).
- `frame_done` out 1: one-cycle pulse with pixel (H_VISIBLE-1, V_VISIBLE-1).
- `lit_count` out 19: number of pixels with nonzero rgb in the last completed frame.
- `frame_count` out 8: completed locked frames; wraps 255 -> 0.
- `sync_error` out 1: one-cycle pulse on any timing violation.

## Operation

**Input stage**
- All five inputs are registered once (stage S1).
- A second register (S0) holds the previous sample, used for edge detection.
- Assertion edge: S0 deasserted and S1 asserted. Deassertion edge: the reverse.

**Counters**
- `h_cnt` is 11 bits and wraps at H_TOTAL-1 -> 0. Each wrap increments `v_cnt`.
- `v_cnt` is 10 bits and wraps at V_TOTAL-1 -> 0.
- Expected counter value at an hsync assertion edge: HS_EXP = H_VISIBLE + H_FRONT (824).
- Expected `v_cnt` at a vsync assertion edge: VS_EXP = V_VISIBLE + V_FRONT (601), with `h_cnt` = HS_EXP.

**Width counters**
- `hs_w` counts cycles while hsync is asserted.
- `vs_w` is 21 bits and counts cycles while vsync is asserted.
- Both are compared at the deassertion edge against H_SYNC and V_SYNC*H_TOTAL respectively.

**State machine**
- UNLOCKED
  - On an hsync assertion edge: load `h_cnt` = HS_EXP, clear `h_ok`, go to HLOCK.
  - All vsync activity is ignored in this state.
- HLOCK
  - hsync assertion edge with `h_cnt` == HS_EXP: set `h_ok`.
  - hsync assertion edge with any other count: reload `h_cnt` and clear `h_ok`. This does not pulse `sync_error`.
  - vsync assertion edge with `h_ok` = 1: load `v_cnt` = VS_EXP and go to LOCKED.
- LOCKED
  - Any of the following pulses `sync_error` and returns to UNLOCKED:
    - hsync edge with `h_cnt` != HS_EXP
    - vsync edge with (`v_cnt`, `h_cnt`) != (VS_EXP, HS_EXP)
    - hsync width != H_SYNC
    - vsync width != V_SYNC*H_TOTAL
  - On return to UNLOCKED, the in-progress `lit_count` accumulation is discarded.
  - If an hsync assertion edge also causes the violation, it is not reused to enter HLOCK in the same cycle. Re-acquisition starts on the next edge.

**Pixel path** (LOCKED only)
- `pix_valid` = (`h_cnt` < H_VISIBLE) && (`v_cnt` < V_VISIBLE).
- `pix_x` = `h_cnt`, `pix_y` = `v_cnt`, `pix_rgb` = S1 colour.
- `frame_start` asserts at (0,0).
- At (H_VISIBLE-1, V_VISIBLE-1):
  - `lit_count` <= accumulator including this pixel.
  - `frame_count` increments.
  - `frame_done` pulses.
  - The accumulator clears.
- A frame counts as complete only if the decoder was LOCKED at that frame's (0,0). A partial first frame produces no `frame_done`.

**Reset values**
- All outputs are 0; the state is UNLOCKED.
- All counters, S0/S1 and the accumulator are 0.
- Reset overrides every event in the same cycle.

## Timing

- Pixel outputs and pulses are registered. The input at cycle t appears on outputs at t+2 (S1 capture at t+1, output register at t+2).
- `locked` rises 2 cycles after the qualifying vsync edge sample.
- `sync_error` pulses 2 cycles after the offending input sample; `locked` falls in the same cycle.
- Throughput: one pixel per clock with no stall.
- `frame_start` and `frame_done` never coincide.

## Test plan

1. **Ideal lock:** drive 3 frames of ideal default timing, all black.
   - `locked` rises within the first frame.
   - `sync_error` stays 0.
   - `frame_count` = 2 after 3 frames, and `lit_count` = 0.
2. **Pixel mapping:** drive a single lit pixel at (799,599), white, for 2 locked frames.
   - `pix_x` = 799, `pix_y` = 599, `pix_rgb` = 3'b111, with `pix_valid` high, 2 cycles after the sample.
   - `frame_done` pulses in that same cycle.
   - `lit_count` = 1.
3. **Full lit frame:** drive all visible pixels red.
   - `lit_count` = 480000.
   - `frame_start` pulses exactly once per 640000 clocks.
4. **Short hsync:** while locked, shorten one hsync pulse to 71 cycles.
   - `sync_error` pulses once and `locked` drops.
   - The decoder relocks at the next qualified vsync edge.
5. **Counter wrap:** run 257 locked frames.
   - `frame_count` wraps 255 -> 0 -> 1.
6. **Reset mid-frame:** assert `reset` for 1 cycle at (400,300).
   - All outputs read 0 the next cycle.
   - No `frame_done` occurs until a full frame after relock.

Source files
------------

// File: rtl/vga_decoder.sv
// vga_decoder: receive-side VGA timing decoder.
// Locks to a sync raster, rebuilds pixel coordinates, colour and frame stats.
module vga_decoder #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 72,
    parameter int H_BACK    = 128,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 22,
    parameter int SYNC_POL  = 1
) (
    input  logic        clk_36MHz,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        red,
    input  logic        green,
    input  logic        blue,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic        frame_start,
    output logic        frame_done,
    output logic [18:0] lit_count,
    output logic [7:0]  frame_count,
    output logic        sync_error
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_EXP   = H_VISIBLE + H_FRONT;
    localparam int VS_EXP   = V_VISIBLE + V_FRONT;
    localparam int VS_WIDTH = V_SYNC * H_TOTAL;

    localparam logic        POL        = (SYNC_POL != 0);
    localparam logic [10:0] HS_EXP_C   = 11'(HS_EXP);
    localparam logic [10:0] HS_NEXT_C  = 11'(HS_EXP + 1);
    localparam logic [10:0] H_LAST_C   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_C    = 11'(H_VISIBLE);
    localparam logic [10:0] H_PLAST_C  = 11'(H_VISIBLE - 1);
    localparam logic [9:0]  VS_EXP_C   = 10'(VS_EXP);
    localparam logic [9:0]  V_LAST_C   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS_C    = 10'(V_VISIBLE);
    localparam logic [9:0]  V_PLAST_C  = 10'(V_VISIBLE - 1);
    localparam logic [10:0] HS_W_C     = 11'(H_SYNC);
    localparam logic [20:0] VS_W_C     = 21'(VS_WIDTH);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        HLOCK    = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [4:0]  s1_q;
    logic [1:0]  s0_q;
    logic        h_ok_q, h_ok_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [10:0] hs_w_q, hs_w_d;
    logic [20:0] vs_w_q, vs_w_d;

    logic        armed_q, armed_d;
    logic [18:0] acc_q, acc_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic [2:0]  pix_rgb_q, pix_rgb_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    logic [18:0] lit_count_q, lit_count_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        sync_error_q, sync_error_d;

    logic        hs_on, hs_prev, hs_rise, hs_fall;
    logic        vs_on, vs_prev, vs_rise, vs_fall;
    logic        h_match, v_match, h_wrap;
    logic        h_reload, v_reload, viol;
    logic        hs_w_bad, vs_w_bad;
    logic        lock_d, vis, first, last, lit;
    logic [2:0]  rgb;

    // S1 holds {hsync, vsync, r, g, b}; S0 keeps the previous sync sample
    assign hs_on   = (s1_q[4] == POL);
    assign vs_on   = (s1_q[3] == POL);
    assign hs_prev = (s0_q[1] == POL);
    assign vs_prev = (s0_q[0] == POL);
    assign hs_rise = hs_on & ~hs_prev;
    assign hs_fall = ~hs_on & hs_prev;
    assign vs_rise = vs_on & ~vs_prev;
    assign vs_fall = ~vs_on & vs_prev;
    assign rgb     = s1_q[2:0];

    assign h_match  = (h_cnt_q == HS_EXP_C);
    assign v_match  = (v_cnt_q == VS_EXP_C);
    assign h_wrap   = (h_cnt_q == H_LAST_C);
    assign hs_w_bad = hs_fall && (hs_w_q != HS_W_C);
    assign vs_w_bad = vs_fall && (vs_w_q != VS_W_C);

    always_comb begin
        state_d  = state_q;
        h_ok_d   = h_ok_q;
        h_reload = 1'b0;
        v_reload = 1'b0;
        viol     = 1'b0;
        unique case (state_q)
            UNLOCKED: begin
                if (hs_rise) begin
                    h_reload = 1'b1;
                    h_ok_d   = 1'b0;
                    state_d  = HLOCK;
                end
            end
            HLOCK: begin
                if (hs_rise) begin
                    if (h_match) begin
                        h_ok_d = 1'b1;
                    end else begin
                        h_reload = 1'b1;
                        h_ok_d   = 1'b0;
                    end
                end
                if (vs_rise && h_ok_q && !(hs_rise && !h_match)) begin
                    v_reload = 1'b1;
                    state_d  = LOCKED;
                end
            end
            LOCKED: begin
                viol = (hs_rise && !h_match)
                    || (vs_rise && !(h_match && v_match))
                    || hs_w_bad
                    || vs_w_bad;
                if (viol) begin
                    state_d = UNLOCKED;
                end
            end
            default: begin
                state_d = UNLOCKED;
            end
        endcase
    end

    // counters track the sample currently held in S1
    always_comb begin
        h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST_C) ? 10'd0 : v_cnt_q + 10'd1;
        end
        if (h_reload) begin
            h_cnt_d = HS_NEXT_C;
            v_cnt_d = v_cnt_q;
        end
        if (v_reload) begin
            v_cnt_d = VS_EXP_C;
        end
    end

    always_comb begin
        hs_w_d = hs_w_q;
        vs_w_d = vs_w_q;
        if (hs_rise) begin
            hs_w_d = 11'd1;
        end else if (hs_on && hs_w_q != '1) begin
            hs_w_d = hs_w_q + 11'd1;
        end
        if (vs_rise) begin
            vs_w_d = 21'd1;
        end else if (vs_on && vs_w_q != '1) begin
            vs_w_d = vs_w_q + 21'd1;
        end
    end

    assign lock_d = (state_d == LOCKED);
    assign vis    = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    assign first  = (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);
    assign last   = (h_cnt_q == H_PLAST_C) && (v_cnt_q == V_PLAST_C);
    assign lit    = vis && (rgb != 3'b000);

    always_comb begin
        pix_valid_d   = lock_d && vis;
        pix_x_d       = lock_d ? h_cnt_q[9:0] : 10'd0;
        pix_y_d       = lock_d ? v_cnt_q : 10'd0;
        pix_rgb_d     = lock_d ? rgb : 3'b000;
        frame_start_d = lock_d && first;
        frame_done_d  = 1'b0;
        lit_count_d   = lit_count_q;
        frame_count_d = frame_count_q;
        sync_error_d  = viol;
        armed_d       = armed_q;
        acc_d         = acc_q + 19'(lit);
        // a frame only counts if we were locked at its first pixel
        if (!lock_d) begin
            armed_d = 1'b0;
            acc_d   = 19'd0;
        end else if (first) begin
            armed_d = 1'b1;
            acc_d   = 19'(lit);
        end else if (last) begin
            acc_d = 19'd0;
            if (armed_q) begin
                frame_done_d  = 1'b1;
                lit_count_d   = acc_q + 19'(lit);
                frame_count_d = frame_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            s1_q    <= '0;
            s0_q    <= '0;
            state_q <= UNLOCKED;
            h_ok_q  <= 1'b0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_w_q  <= '0;
            vs_w_q  <= '0;
        end else begin
            s1_q    <= {hsync, vsync, red, green, blue};
            s0_q    <= s1_q[4:3];
            state_q <= state_d;
            h_ok_q  <= h_ok_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_w_q  <= hs_w_d;
            vs_w_q  <= vs_w_d;
        end
    end

    always_ff @(posedge clk_36MHz) begin
        if (reset) begin
            armed_q       <= 1'b0;
            acc_q         <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            lit_count_q   <= '0;
            frame_count_q <= '0;
            sync_error_q  <= 1'b0;
        end else begin
            armed_q       <= armed_d;
            acc_q         <= acc_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            lit_count_q   <= lit_count_d;
            frame_count_q <= frame_count_d;
            sync_error_q  <= sync_error_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign lit_count   = lit_count_q;
    assign frame_count = frame_count_q;
    assign sync_error  = sync_error_q;

endmodule
